ula_seq: RTL

Sequencing and accumulator stage that sits directly upstream of the 4-bit combinational ALU (`ula`) and consumes its result. It accepts operation commands over a valid/ready handshake, drives the ALU's `a`/`b`/`op` inputs from registers, and captures `r`/`zero` into an accumulator. It then presents the result downstream on a second valid/ready handshake. Results can be chained, so a command may use the previous result as operand A.

---
 rtl/ula_seq.sv | 109 ++++++++++
 1 files changed

// File: rtl/ula_seq.sv
// Sequencer/accumulator in front of the 4-bit combinational ALU: registers operands, captures result.
// Optional completed-operation counter enabled by defining ULA_SEQ_CNT_EN.
module ula_seq #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic         cmd_use_acc,
  input  logic [W-1:0] cmd_a,
  input  logic [W-1:0] cmd_b,
  output logic [W-1:0] ula_a,
  output logic [W-1:0] ula_b,
  output logic [2:0]   ula_op,
  input  logic [W-1:0] ula_r,
  input  logic         ula_zero,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [W-1:0] res_data,
  output logic         res_zero,
  output logic [W-1:0] acc,
  output logic [7:0]   op_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2:0]     op_q;
  logic [W-1:0]   acc_q;
  logic [W-1:0]   data_q;
  logic           zero_q;
  logic           valid_q;

`ifdef ULA_SEQ_CNT_EN
  localparam int unsigned CNT_W   = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] cnt_q;
`endif

  // Ready depends on state alone so upstream never sees a valid->ready loop.
  assign cmd_ready = (state_q == IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      zero_q  <= 1'b0;
      valid_q <= 1'b0;
`ifdef ULA_SEQ_CNT_EN
      cnt_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            op_q    <= cmd_op;
            b_q     <= cmd_b;
            a_q     <= cmd_use_acc ? acc_q : cmd_a;
            state_q <= EXEC;
          end
        end
        EXEC: begin
          acc_q   <= ula_r;
          data_q  <= ula_r;
          zero_q  <= ula_zero;
          valid_q <= 1'b1;
          state_q <= RESP;
`ifdef ULA_SEQ_CNT_EN
          if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
`endif
        end
        RESP: begin
          if (valid_q && res_ready) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ula_a     = a_q;
  assign ula_b     = b_q;
  assign ula_op    = op_q;
  assign acc       = acc_q;
  assign res_data  = data_q;
  assign res_zero  = zero_q;
  assign res_valid = valid_q;

`ifdef ULA_SEQ_CNT_EN
  assign op_count = cnt_q;
`else
  assign op_count = 8'd0;
`endif

endmodule
